// File: rtl/planificador_solicitudes.sv
// Elevator request scheduler: latches call codes into a pending register and
// picks the next target floor with an up/down sweep, presenting its code on memoria.
module planificador_solicitudes #(
  parameter int N_COD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LE,
  input  logic       puertas,
  input  logic [1:0] accion,
  input  logic [1:0] piso,
  input  logic [3:0] boton_pres,
  output logic [3:0] memoria
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} dir_e;

  logic [N_COD:1] p_q, p_d;
  logic [N_COD:1] clr_mask;
  logic [3:0]     prev_q, prev_d;
  dir_e           dir_q, dir_d;
  logic [3:0]     memoria_q, memoria_d;

  logic [3:0]     fp;
  logic [3:0]     code [4];
  logic           above_found, below_found;
  logic [1:0]     above_lo, below_hi;
  logic           tgt_valid;
  logic [1:0]     tgt;

  assign fp[0] = p_q[1] | p_q[5];
  assign fp[1] = p_q[2] | p_q[6] | p_q[7];
  assign fp[2] = p_q[3] | p_q[8] | p_q[9];
  assign fp[3] = p_q[4] | p_q[10];

  // Lowest-numbered pending code of each floor.
  always_comb begin
    code[0] = p_q[1] ? 4'd1 : (p_q[5] ? 4'd5 : 4'd0);
    code[1] = p_q[2] ? 4'd2 : (p_q[6] ? 4'd6 : (p_q[7] ? 4'd7 : 4'd0));
    code[2] = p_q[3] ? 4'd3 : (p_q[8] ? 4'd8 : (p_q[9] ? 4'd9 : 4'd0));
    code[3] = p_q[4] ? 4'd4 : (p_q[10] ? 4'd10 : 4'd0);
  end

  // Nearest pending floor strictly above and strictly below the cabin.
  always_comb begin
    above_found = 1'b0;
    above_lo    = 2'd0;
    below_found = 1'b0;
    below_hi    = 2'd0;
    for (int f = 3; f >= 0; f--) begin
      if (2'(f) > piso && fp[f]) begin
        above_found = 1'b1;
        above_lo    = 2'(f);
      end
    end
    for (int f = 0; f <= 3; f++) begin
      if (2'(f) < piso && fp[f]) begin
        below_found = 1'b1;
        below_hi    = 2'(f);
      end
    end
  end

  always_comb begin
    dir_d     = dir_q;
    tgt_valid = 1'b0;
    tgt       = piso;
    case (dir_q)
      S_IDLE: begin
        if (fp[piso]) begin
          tgt_valid = 1'b1;
        end else if (below_found &&
                     (!above_found || (piso - below_hi) <= (above_lo - piso))) begin
          tgt_valid = 1'b1;
          tgt       = below_hi;
          dir_d     = S_DOWN;
        end else if (above_found) begin
          tgt_valid = 1'b1;
          tgt       = above_lo;
          dir_d     = S_UP;
        end
      end
      S_UP: begin
        if (fp[piso]) begin
          tgt_valid = 1'b1;
        end else if (above_found) begin
          tgt_valid = 1'b1;
          tgt       = above_lo;
        end else if (below_found) begin
          tgt_valid = 1'b1;
          tgt       = below_hi;
          dir_d     = S_DOWN;
        end else begin
          dir_d = S_IDLE;
        end
      end
      S_DOWN: begin
        if (fp[piso]) begin
          tgt_valid = 1'b1;
        end else if (below_found) begin
          tgt_valid = 1'b1;
          tgt       = below_hi;
        end else if (above_found) begin
          tgt_valid = 1'b1;
          tgt       = above_lo;
          dir_d     = S_UP;
        end else begin
          dir_d = S_IDLE;
        end
      end
      default: dir_d = S_IDLE;
    endcase
  end

  always_comb begin
    memoria_d = memoria_q;
    if (LE) memoria_d = tgt_valid ? code[tgt] : 4'd0;
  end

  always_comb begin
    case (piso)
      2'd0:    clr_mask = 10'b0000010001;
      2'd1:    clr_mask = 10'b0001100010;
      2'd2:    clr_mask = 10'b0110000100;
      default: clr_mask = 10'b1000001000;
    endcase
  end

  always_comb begin
    prev_d = boton_pres;
    p_d    = p_q;
    if (boton_pres != prev_q && boton_pres >= 4'd1 && boton_pres <= 4'(N_COD))
      p_d[boton_pres] = 1'b1;
    // Clear is applied after capture so a same-cycle press at the served floor is dropped.
    if (puertas && accion == 2'd0 && LE)
      p_d = p_d & ~clr_mask;
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values computed by the combinational blocks above.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q       <= '0;
      prev_q    <= 4'd0;
      dir_q     <= S_IDLE;
      memoria_q <= 4'd0;
    end else begin
      p_q       <= p_d;
      prev_q    <= prev_d;
      dir_q     <= dir_d;
      memoria_q <= memoria_d;
    end
  end

  assign memoria = memoria_q;

endmodule

// File: tb/tb_planificador_solicitudes.sv
// Scoreboard bench for planificador_solicitudes: a behavioural model predicts
// memoria per edge, a monitor compares it on the falling edge.
module tb_planificador_solicitudes;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       LE = 1'b1;
  logic       puertas = 1'b0;
  logic [1:0] accion = 2'd0;
  logic [1:0] piso = 2'd0;
  logic [3:0] boton_pres = 4'd0;
  logic [3:0] memoria;

  always #5 clk = ~clk;

  planificador_solicitudes #(.N_COD(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .LE         (LE),
    .puertas    (puertas),
    .accion     (accion),
    .piso       (piso),
    .boton_pres (boton_pres),
    .memoria    (memoria)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  // Reference model: set of pending codes, heading (0 none, +1 up, -1 down).
  bit m_pend[1:10];
  int m_prev = 0;
  int m_dir = 0;
  int m_mem = 0;
  int rb = 0;
  int rp = 0;

  task automatic check(input string name, input logic [3:0] act, input int expv);
    vectors++;
    if (act !== 4'(expv)) begin
      miscompares++;
      $display("FAIL %s: memoria=%0d expected=%0d at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic int floor_of(input int c);
    case (c)
      1, 5:    return 0;
      2, 6, 7: return 1;
      3, 8, 9: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int search(input bit fpv[4], input int p, input int dir);
    for (int f = p + dir; f >= 0 && f <= 3; f += dir)
      if (fpv[f]) return f;
    return -1;
  endfunction

  task automatic model_step();
    bit fpv[4];
    int tgt;
    int p = int'(piso);
    int b = int'(boton_pres);
    if (rst) begin
      foreach (m_pend[c]) m_pend[c] = 1'b0;
      m_prev = 0;
      m_dir  = 0;
      m_mem  = 0;
      return;
    end
    foreach (fpv[f]) fpv[f] = 1'b0;
    foreach (m_pend[c]) if (m_pend[c]) fpv[floor_of(c)] = 1'b1;
    tgt = -1;
    if (fpv[p]) begin
      tgt = p;
    end else if (m_dir == 0) begin
      for (int d = 1; d <= 3 && tgt < 0; d++) begin
        if (p - d >= 0 && fpv[p - d]) tgt = p - d;
        else if (p + d <= 3 && fpv[p + d]) tgt = p + d;
      end
      if (tgt >= 0) m_dir = (tgt > p) ? 1 : -1;
    end else begin
      tgt = search(fpv, p, m_dir);
      if (tgt < 0) begin
        tgt = search(fpv, p, -m_dir);
        m_dir = (tgt >= 0) ? -m_dir : 0;
      end
    end
    if (LE) begin
      m_mem = 0;
      if (tgt >= 0)
        for (int c = 10; c >= 1; c--)
          if (m_pend[c] && floor_of(c) == tgt) m_mem = c;
    end
    if (b != m_prev && b >= 1 && b <= 10) m_pend[b] = 1'b1;
    if (puertas && accion == 2'd0 && LE)
      foreach (m_pend[c]) if (floor_of(c) == p) m_pend[c] = 1'b0;
    m_prev = b;
  endtask

  task automatic step(input bit r, input bit le, input bit pu, input int ac,
                      input int ps, input int b);
    rst = r; LE = le; puertas = pu;
    accion = 2'(ac); piso = 2'(ps); boton_pres = 4'(b);
    model_step();
    @(posedge clk);
    exp_q.push_back(m_mem);
    #1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) check("memoria_sb", memoria, exp_q.pop_front());
    end
  end

  initial begin : stimulus
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0, 0, 0);
    check("reset_idle", memoria, 0);

    step(0, 1, 0, 0, 0, 3);
    step(0, 1, 0, 0, 0, 3);
    check("press_latency", memoria, 3);
    repeat (48) step(0, 1, 0, 0, 0, 3);
    check("held_press", memoria, 3);
    step(0, 1, 0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0, 3);
    check("repress", memoria, 3);
    step(0, 1, 0, 0, 0, 9);
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check("rst_mid_sweep", memoria, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    check("rst_discards", memoria, 0);

    step(1, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 4);
    step(0, 1, 0, 0, 1, 1);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    check("up_target", memoria, 4);
    step(0, 1, 1, 0, 3, 0);
    step(0, 1, 1, 0, 3, 0);
    check("reverse_down", memoria, 1);

    step(1, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 2);
    step(0, 1, 0, 0, 1, 5);
    step(0, 1, 0, 0, 1, 9);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    check("idle_here", memoria, 2);
    step(0, 1, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    check("tie_lower", memoria, 5);
    step(0, 1, 0, 0, 1, 0);

    step(1, 1, 0, 0, 3, 0);
    step(0, 1, 0, 0, 3, 1);
    step(0, 1, 0, 0, 3, 0);
    step(0, 1, 0, 0, 3, 0);
    check("pre_freeze", memoria, 1);
    repeat (20) step(0, 0, 0, 0, 3, 10);
    check("le_frozen", memoria, 1);
    step(0, 1, 0, 0, 3, 10);
    check("le_release", memoria, 10);

    step(1, 1, 0, 0, 1, 0);
    repeat (3) step(0, 1, 1, 0, 1, 7);
    step(0, 1, 0, 0, 1, 7);
    step(0, 1, 0, 0, 1, 7);
    check("clear_wins", memoria, 0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) rb = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rp = int'($urandom_range(0, 3));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 2)), rp, rb);
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/planificador_solicitudes.md
# planificador_solicitudes

Request scheduler between the button encoder and the elevator floor state machine. It latches every call code arriving on `boton_pres` into a pending-request register and runs an up/down sweep policy. It presents the single next target code on `memoria`, which the floor state machine samples when it issues a decision. Served requests are cleared when the cabin stands with doors open at their floor.

## Interface
- `N_COD`, 10: number of valid call codes (1..10); codes 0 and 11..15 carry no request.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `LE`  in  1  load enable; 1 = `memoria` may update, 0 = `memoria` frozen (state machine sampling).
- `puertas`  in  1  door status from state machine; 1 = open.
- `accion`  in  2  cabin motion; 0 idle, 1 up, 2 down.
- `piso`  in  2  current floor, 0..3 = floors 1..4.
- `boton_pres`  in  4  encoded button: 1..4 cabin call floor 1..4; 5 F1 up; 6 F2 down; 7 F2 up; 8 F3 down; 9 F3 up; 10 F4 down; 0 none.
- `memoria`  out  4  next target code, 0 = no request.

## Operation
- Codes by floor: floor 0 = {1,5}; floor 1 = {2,6,7}; floor 2 = {3,8,9}; floor 3 = {4,10}.
- Pending register `p[1..10]`.
- Capture: `prev` holds last cycle's `boton_pres`. When `boton_pres != prev` and `boton_pres` is in 1..10, set `p[boton_pres]`. A held button sets its bit once only.
- Clear: when `puertas==1`, `accion==0` and `LE==1`, clear every bit of floor `piso`. If a capture and a clear hit the same bit in the same cycle, the clear wins.
- Floor pending `fp[f]` = OR of the bits of floor f.
- `code(f)` = lowest-numbered pending bit of floor f.
- Direction FSM: IDLE, UP, DOWN.
  - IDLE:
    - `fp[piso]` set: target = `piso`; stay IDLE.
    - Else, any `fp` set: target = nearest pending floor; on a tie, the lower floor wins. Go to UP if target > `piso`, else DOWN.
    - Else: target none.
  - UP:
    - `fp[piso]` set: target = `piso`.
    - Else, any floor above pending: target = lowest pending floor above `piso`.
    - Else, any floor below pending: go to DOWN; target = highest pending floor below `piso`.
    - Else: go to IDLE; target none.
  - DOWN: mirror of UP. Search below first, highest pending floor below; otherwise reverse to UP.
- `memoria` register:
  - When `LE==1`, load `code(target)`, or 0 if no target.
  - When `LE==0`, hold.
- FSM and pending bits keep updating while `LE==0`; only `memoria` is frozen.
- Codes 11..15 are ignored and do not disturb `prev`-based edge detection beyond being a change of value.

## Timing
- Reset values: `p` = 0, `prev` = 0, FSM = IDLE, `memoria` = 0. `rst` mid-sweep discards all pending requests on the next edge.
- Press latency, with `LE` high throughout:
  - `boton_pres` changes at edge n.
  - `p` bit is set at edge n+1.
  - FSM and `memoria` reflect it at edge n+2.
- Clear latency: the clear condition sampled at edge n leaves the bits cleared after edge n. `memoria` shows the new target after edge n+1.
- `LE` low for k cycles: `memoria` is constant for those k cycles and updates on the first edge with `LE==1`.
- FSM transitions are registered: one transition per clock, evaluated on the current `p` and `piso`.
- `piso` changes are consumed the cycle they appear; no internal delay.

## Test plan
- Reset, then idle at `piso`=0 with no presses: `memoria`=0, FSM IDLE. Assert `rst` after loading codes 3 and 9: `memoria`=0 and `p`=0 one edge later.
- At `piso`=0, press code 3 (held 50 cycles): `p[3]` set once, `memoria`=3 two edges after the press, FSM UP. Release and re-press: no duplicate side effect.
- At `piso`=1 in UP with codes 1 and 4 pending: `memoria`=4. At `piso`=3 with doors open and `accion`=0: `p[4]` cleared, FSM DOWN, `memoria`=1.
- At `piso`=1 in IDLE, press 5 and 9 together-sequenced (floors 0 and 2, equidistant): `memoria`=5 (lower floor wins), FSM DOWN.
- Hold `LE`=0 for 20 cycles while pressing code 10: `memoria` unchanged through the window, then becomes 10 on the first `LE`=1 edge.
- Same-cycle press of code 7 while `piso`=1, `puertas`=1, `accion`=0, `LE`=1: `p[7]` remains 0 and `memoria` does not become 7.
